// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin selection
// function for the FIFO write arbiter.
package fifo_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    STALL = 2'd2
  } arb_state_t;

  // First eligible index strictly after ptr,
  // searching circularly over n requesters.
  function automatic logic [IDX_W-1:0] rr_next(
    input logic [MAX_REQ-1:0] eligible,
    input logic [IDX_W-1:0]   ptr,
    input int                 n
  );
    logic [IDX_W-1:0] win;
    logic             found;
    int               j;
    win   = ptr;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      j = (int'(ptr) + k) % n;
      if (k <= n && !found &&
          eligible[j[IDX_W-1:0]]) begin
        win   = j[IDX_W-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_pick.sv
// Combinational round-robin picker used by
// the FIFO write arbiter.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [MAX_REQ-1:0] elig_ext;

  assign elig_ext = MAX_REQ'(eligible);
  assign idx      = rr_next(elig_ext, rr_ptr,
                            NUM_REQ);
  assign any      = |eligible;
  assign onehot   = any ? (NUM_REQ'(1) << idx)
                        : '0;

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write
// port, with full throttling and ack checking.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]      gnt,
  output logic                    wr_en,
  output logic [FIFO_WIDTH-1:0]   data_in,
  input  logic                    full,
  input  logic                    almostfull,
  input  logic                    wr_ack,
  input  logic                    overflow,
  output logic                    ack_err,
  output logic [1:0]              arb_state,
  output logic [CNT_W-1:0]        wr_count
);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ ||
      FIFO_DEPTH < 2) begin : g_bad_cfg
    $error("fifo_wr_arb: bad parameters");
  end

  logic [NUM_REQ-1:0]    elig;
  logic [NUM_REQ-1:0]    pick_oh;
  logic [IDX_W-1:0]      pick_idx;
  logic [IDX_W-1:0]      rr_ptr;
  logic                  pick_any;
  logic                  blocked;
  logic                  issue;
  logic                  ack_pend;
  logic [FIFO_WIDTH-1:0] pick_data;
  arb_state_t            state_q;
  arb_state_t            state_d;

  // Mask this cycle's grant so it is not
  // taken a second time.
  assign elig    = req & ~gnt;
  assign blocked = full | (almostfull & wr_en);
  assign issue   = pick_any & ~blocked;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .eligible (elig),
    .rr_ptr   (rr_ptr),
    .onehot   (pick_oh),
    .idx      (pick_idx),
    .any      (pick_any)
  );

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) begin
        pick_data = pick_data |
          req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = IDLE;
    unique case (1'b1)
      issue:              state_d = WRITE;
      pick_any & blocked: state_d = STALL;
      default:            state_d = IDLE;
    endcase
  end

  assign arb_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt      <= '0;
      wr_en    <= 1'b0;
      data_in  <= '0;
      wr_count <= '0;
      rr_ptr   <= IDX_W'(NUM_REQ - 1);
    end else begin
      gnt   <= issue ? pick_oh : '0;
      wr_en <= issue;
      if (issue) begin
        data_in  <= pick_data;
        rr_ptr   <= pick_idx;
        wr_count <= wr_count + CNT_W'(1);
      end
    end
  end

  // A write driven this cycle owes an ack on
  // the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_pend <= 1'b0;
      ack_err  <= 1'b0;
    end else begin
      ack_pend <= wr_en;
      if ((ack_pend & ~wr_ack) | overflow) begin
        ack_err <= 1'b1;
      end
    end
  end

  a_gnt_onehot: assert property (
    @(posedge clk) disable iff (!rst_n)
    $onehot0(gnt) && (wr_en == (|gnt))
  );

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Randomized bench for fifo_wr_arb against a
// behavioural arbiter and FIFO model.
module tb_fifo_wr_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  gnt;
  logic        wr_en;
  logic [7:0]  data_in;
  logic        full = 1'b0;
  logic        almostfull = 1'b0;
  logic        wr_ack = 1'b0;
  logic        overflow = 1'b0;
  logic        ack_err;
  logic [1:0]  arb_state;
  logic [3:0]  wr_count;

  fifo_wr_arb #(
    .NUM_REQ    (4),
    .FIFO_WIDTH (8),
    .FIFO_DEPTH (16),
    .CNT_W      (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .wr_en      (wr_en),
    .data_in    (data_in),
    .full       (full),
    .almostfull (almostfull),
    .wr_ack     (wr_ack),
    .overflow   (overflow),
    .ack_err    (ack_err),
    .arb_state  (arb_state),
    .wr_count   (wr_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] dq [4];
  logic [3:0] m_gnt;
  bit         m_wr;
  logic [7:0] m_data;
  int         m_ptr;
  int         m_cnt;
  int         m_state;
  bit         m_err;
  bit         m_pend;
  int         f_cnt;
  bit         f_ack;
  bit         f_ovf;
  int         gnt_seen;
  bit         ovf_seen;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  function automatic int winner(
    input logic [3:0] e, input int p);
    for (int k = 1; k <= 4; k++) begin
      if (e[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_gnt = '0; m_wr = 0; m_data = '0;
    m_ptr = 3; m_cnt = 0; m_state = 0;
    m_err = 0; m_pend = 0;
    f_cnt = 0; f_ack = 0; f_ovf = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    req = '0;
    full = 0; almostfull = 0;
    wr_ack = 0; overflow = 0;
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_data", 32'(data_in), 0);
    chk("rst_state", 32'(arb_state), 0);
    chk("rst_count", 32'(wr_count), 0);
    chk("rst_err", 32'(ack_err), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic tick(input logic [3:0] r,
                      input bit rd,
                      input bit sup);
    logic [3:0] elig;
    bit         blk;
    bit         dw;
    int         w;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (r[i] && (!req[i] || m_gnt[i]))
        dq[i] = 8'($urandom);
    end
    req        = r;
    req_data   = {dq[3], dq[2], dq[1], dq[0]};
    full       = (f_cnt == 16);
    almostfull = (f_cnt == 15);
    wr_ack     = f_ack;
    overflow   = f_ovf;
    dw         = wr_en;
    @(posedge clk);
    if ((m_pend && !f_ack) || f_ovf) m_err = 1;
    m_pend = m_wr;
    elig = r & ~m_gnt;
    blk  = (f_cnt == 16) ||
           (f_cnt == 15 && m_wr);
    w = winner(elig, m_ptr);
    if (w >= 0 && !blk) begin
      m_gnt   = 4'(1 << w);
      m_wr    = 1;
      m_data  = dq[w];
      m_ptr   = w;
      m_cnt   = (m_cnt + 1) % 16;
      m_state = 1;
      gnt_seen++;
    end else begin
      m_gnt   = '0;
      m_wr    = 0;
      m_state = (elig != 0) ? 2 : 0;
    end
    f_ovf = dw && (f_cnt == 16);
    ovf_seen |= f_ovf;
    f_ack = dw && (f_cnt < 16) && !sup;
    f_cnt = f_cnt +
            ((dw && f_cnt < 16) ? 1 : 0) -
            ((rd && f_cnt > 0) ? 1 : 0);
    #1;
    chk("gnt", 32'(gnt), 32'(m_gnt));
    chk("wr_en", 32'(wr_en), 32'(m_wr));
    chk("data_in", 32'(data_in), 32'(m_data));
    chk("state", 32'(arb_state), m_state);
    chk("wr_count", 32'(wr_count), m_cnt);
    chk("ack_err", 32'(ack_err), 32'(m_err));
  endtask

  initial begin
    logic [3:0] r;
    for (int i = 0; i < 4; i++) dq[i] = '0;
    model_reset();
    do_reset();

    // fairness with a draining FIFO
    gnt_seen = 0;
    repeat (8) tick(4'hf, 1, 0);
    chk("rr_count8", 32'(wr_count), 8);
    chk("rr_grants", gnt_seen, 8);
    repeat (4) tick(4'hf, 1, 0);

    // single requester
    do_reset();
    repeat (8) tick(4'b0100, 1, 0);

    // full throttle
    do_reset();
    gnt_seen = 0;
    ovf_seen = 0;
    repeat (24) tick(4'hf, 0, 0);
    chk("fill_grants", gnt_seen, 16);
    chk("fill_level", f_cnt, 16);
    chk("fill_stall", 32'(arb_state), 2);
    tick(4'hf, 1, 0);
    repeat (4) tick(4'hf, 0, 0);
    chk("read_grants", gnt_seen, 17);
    chk("no_overflow", 32'(ovf_seen), 0);

    // counter wrap
    do_reset();
    repeat (17) tick(4'hf, 1, 0);
    chk("wrap", 32'(wr_count), 1);

    // missing ack
    do_reset();
    tick(4'b0100, 1, 0);
    tick(4'b0100, 1, 1);
    tick(4'b0100, 1, 0);
    chk("ack_err_set", 32'(ack_err), 1);
    repeat (6) tick(4'($urandom), 1, 0);
    chk("ack_err_hold", 32'(ack_err), 1);

    // randomized traffic
    do_reset();
    for (int n = 0; n < 400; n++) begin
      r = (req & ~m_gnt) |
          (4'($urandom) & 4'($urandom));
      tick(r, ($urandom_range(0, 3) != 0) ||
              (n > 300), 0);
    end

    // reset mid-stream
    repeat (3) tick(4'hf, 1, 0);
    do_reset();
    tick(4'hf, 1, 0);
    chk("first_gnt", 32'(gnt), 1);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
